pipelined_write_assembler: RTL and testbench

- Receives the pipelined-write bus protocol: one command cycle, then 1..MAX_WR_CYCLES data cycles.
- Assembles the data cycles into one wide write and queues it in an OUT_DEPTH-entry output FIFO with a valid/ready handshake.
- Generates per-mode wdone pulses.
- Flags protocol violations and output overflow.
- Sits between the pipelined-write link and the wide-write consumer; it is the parametrised successor of the fixed 4x8 pipelined-write format.

---
 rtl/pipelined_write_assembler.sv | 218 +++++++++++++++++++++
 tb/tb_pipelined_write_assembler.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_write_assembler.sv
// Pipelined-write assembler: gathers 1..MAX_WR_CYCLES data cycles that follow a
// command cycle into one wide write, queues it in a small output FIFO, and
// reports write-done pulses, protocol errors and output overflow.
module pipelined_write_assembler #(
  parameter int unsigned WR_WIDTH      = 8,
  parameter int unsigned MAX_WR_CYCLES = 4,
  parameter int unsigned OUT_DEPTH     = 2,
  localparam int unsigned NCW          = $clog2(MAX_WR_CYCLES),
  localparam int unsigned DW           = MAX_WR_CYCLES * WR_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_cmd_val,
  input  logic [NCW-1:0]      in_num_cycles,
  input  logic [2:0]          in_write_type,
  input  logic [1:0]          in_cycle_type,
  input  logic [WR_WIDTH-1:0] in_dat,
  output logic                out_vld,
  input  logic                out_rdy,
  output logic [DW-1:0]       out_dat,
  output logic [NCW:0]        out_num_cycles,
  output logic [2:0]          out_write_type,
  output logic                wdone,
  output logic                err_proto,
  output logic                err_ovf
);

  localparam int unsigned EW = NCW + 1;
  localparam int unsigned PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int unsigned CW = $clog2(OUT_DEPTH + 1);

  localparam logic [2:0] WtMulti  = 3'd1;
  localparam logic [2:0] WtSingle = 3'd2;

  localparam logic [1:0] CtIdle  = 2'd0;
  localparam logic [1:0] CtValid = 2'd1;
  localparam logic [1:0] CtDone  = 2'd2;

  typedef enum logic {StIdle, StData} state_e;

  state_e        r_state, w_state_nxt;
  logic [EW-1:0] r_exp, w_exp_nxt;
  logic [2:0]    r_type, w_type_nxt;
  logic [NCW-1:0] r_cnt, w_cnt_nxt;
  logic [DW-1:0] r_asm, w_asm_nxt, w_asm_ins;

  logic [EW-1:0] w_cmd_exp;
  logic          w_last;
  logic          w_push;
  logic          w_proto;
  logic          w_beat_ok;

  // Output FIFO storage and control
  logic [DW-1:0] r_fdat  [OUT_DEPTH];
  logic [EW-1:0] r_fnum  [OUT_DEPTH];
  logic [2:0]    r_ftype [OUT_DEPTH];
  logic [PW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_occ;
  logic          w_full, w_pop, w_accept;

  logic r_wdone, r_err_proto, r_err_ovf;
  logic w_wdone_nxt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(OUT_DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  // A zero count on the command means the maximum number of beats.
  assign w_cmd_exp = (in_num_cycles == '0) ? EW'(MAX_WR_CYCLES) : {1'b0, in_num_cycles};
  assign w_last    = ({1'b0, r_cnt} == (r_exp - EW'(1)));

  // Assembly register with the current input beat dropped into its slot.
  always_comb begin
    w_asm_ins = r_asm;
    w_asm_ins[r_cnt*WR_WIDTH +: WR_WIDTH] = in_dat;
  end

  // Next-state and per-cycle event decode for the command/data FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_exp_nxt   = r_exp;
    w_type_nxt  = r_type;
    w_cnt_nxt   = r_cnt;
    w_asm_nxt   = r_asm;
    w_push      = 1'b0;
    w_proto     = 1'b0;
    w_beat_ok   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (in_cmd_val) begin
          w_exp_nxt   = w_cmd_exp;
          w_type_nxt  = in_write_type;
          w_cnt_nxt   = '0;
          w_asm_nxt   = '0;
          w_state_nxt = StData;
        end else if (in_cycle_type != CtIdle) begin
          w_proto = 1'b1;
        end
      end
      StData: begin
        if (in_cmd_val) begin
          // Abandon the write in flight and start the new one immediately.
          w_proto    = 1'b1;
          w_exp_nxt  = w_cmd_exp;
          w_type_nxt = in_write_type;
          w_cnt_nxt  = '0;
          w_asm_nxt  = '0;
        end else begin
          unique case (in_cycle_type)
            CtIdle: ;
            CtValid: begin
              if (!w_last) begin
                w_asm_nxt = w_asm_ins;
                w_cnt_nxt = r_cnt + NCW'(1);
                w_beat_ok = 1'b1;
              end else begin
                w_proto     = 1'b1;
                w_state_nxt = StIdle;
              end
            end
            CtDone: begin
              if (w_last) begin
                w_push    = 1'b1;
                w_beat_ok = 1'b1;
              end else begin
                w_proto = 1'b1;
              end
              w_state_nxt = StIdle;
            end
            default: begin
              w_proto     = 1'b1;
              w_state_nxt = StIdle;
            end
          endcase
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // FSM and assembly registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_exp   <= '0;
      r_type  <= '0;
      r_cnt   <= '0;
      r_asm   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_exp   <= w_exp_nxt;
      r_type  <= w_type_nxt;
      r_cnt   <= w_cnt_nxt;
      r_asm   <= w_asm_nxt;
    end
  end

  assign out_vld  = (r_occ != '0);
  assign w_full   = (r_occ == CW'(OUT_DEPTH));
  assign w_pop    = out_vld && out_rdy;
  // A pop on the same edge frees the slot a full FIFO needs.
  assign w_accept = w_push && (!w_full || w_pop);

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(OUT_DEPTH); i++) begin
        r_fdat[i]  <= '0;
        r_fnum[i]  <= '0;
        r_ftype[i] <= '0;
      end
      r_wp  <= '0;
      r_rp  <= '0;
      r_occ <= '0;
    end else begin
      if (w_accept) begin
        r_fdat[r_wp]  <= w_asm_ins;
        r_fnum[r_wp]  <= r_exp;
        r_ftype[r_wp] <= r_type;
        r_wp          <= ptr_inc(r_wp);
      end
      if (w_pop) begin
        r_rp <= ptr_inc(r_rp);
      end
      if (w_accept && !w_pop) begin
        r_occ <= r_occ + CW'(1);
      end else if (!w_accept && w_pop) begin
        r_occ <= r_occ - CW'(1);
      end
    end
  end

  assign out_dat        = r_fdat[r_rp];
  assign out_num_cycles = r_fnum[r_rp];
  assign out_write_type = r_ftype[r_rp];

  assign w_wdone_nxt = ((r_type == WtMulti) && w_beat_ok) ||
                       ((r_type == WtSingle) && w_accept);

  // Registered one-cycle status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wdone     <= 1'b0;
      r_err_proto <= 1'b0;
      r_err_ovf   <= 1'b0;
    end else begin
      r_wdone     <= w_wdone_nxt;
      r_err_proto <= w_proto;
      r_err_ovf   <= w_push && !w_accept;
    end
  end

  assign wdone     = r_wdone;
  assign err_proto = r_err_proto;
  assign err_ovf   = r_err_ovf;

endmodule

// File: tb/tb_pipelined_write_assembler.sv
// Bench for pipelined_write_assembler: two instances (8x4 default and 16x8),
// a queue-based reference model checked every cycle, plus literal spot checks.
module tb_pipelined_write_assembler;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance 0: WR_WIDTH=8, MAX_WR_CYCLES=4, OUT_DEPTH=2
  logic        a_cmd, a_rdy;
  logic [1:0]  a_nc;
  logic [2:0]  a_wt;
  logic [1:0]  a_ct;
  logic [7:0]  a_dat;
  logic        o0_vld, o0_wd, o0_ep, o0_eo;
  logic [31:0] o0_dat;
  logic [2:0]  o0_num;
  logic [2:0]  o0_wt;

  // Instance 1: WR_WIDTH=16, MAX_WR_CYCLES=8, OUT_DEPTH=2
  logic         b_cmd, b_rdy;
  logic [2:0]   b_nc;
  logic [2:0]   b_wt;
  logic [1:0]   b_ct;
  logic [15:0]  b_dat;
  logic         o1_vld, o1_wd, o1_ep, o1_eo;
  logic [127:0] o1_dat;
  logic [3:0]   o1_num;
  logic [2:0]   o1_wt;

  pipelined_write_assembler u_dut0 (
    .clk(clk), .rst(rst), .in_cmd_val(a_cmd), .in_num_cycles(a_nc),
    .in_write_type(a_wt), .in_cycle_type(a_ct), .in_dat(a_dat),
    .out_vld(o0_vld), .out_rdy(a_rdy), .out_dat(o0_dat), .out_num_cycles(o0_num),
    .out_write_type(o0_wt), .wdone(o0_wd), .err_proto(o0_ep), .err_ovf(o0_eo)
  );

  pipelined_write_assembler #(
    .WR_WIDTH(16), .MAX_WR_CYCLES(8), .OUT_DEPTH(2)
  ) u_dut1 (
    .clk(clk), .rst(rst), .in_cmd_val(b_cmd), .in_num_cycles(b_nc),
    .in_write_type(b_wt), .in_cycle_type(b_ct), .in_dat(b_dat),
    .out_vld(o1_vld), .out_rdy(b_rdy), .out_dat(o1_dat), .out_num_cycles(o1_num),
    .out_write_type(o1_wt), .wdone(o1_wd), .err_proto(o1_ep), .err_ovf(o1_eo)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [127:0] d;
    int           n;
    int           t;
  } ent_t;

  ent_t        fq0[$];
  ent_t        fq1[$];
  bit          busy [2];
  int          exp_n [2];
  int          wtype [2];
  int          nb [2];
  logic [15:0] bt [2][8];
  bit          ew [2];
  bit          eep [2];
  bit          eeo [2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      busy[i] = 0; nb[i] = 0; ew[i] = 0; eep[i] = 0; eeo[i] = 0;
    end
    fq0.delete();
    fq1.delete();
  endtask

  task automatic model_step(input int i);
    int          w, m, nc, wt, ct;
    logic        cmd, rdy;
    logic [15:0] dat;
    ent_t        f[$];
    ent_t        e;
    bit          pop, proto, ovf, wd, push;
    if (i == 0) begin
      w = 8; m = 4; cmd = a_cmd; nc = int'(a_nc); wt = int'(a_wt); ct = int'(a_ct);
      dat = {8'h00, a_dat}; rdy = a_rdy; f = fq0;
    end else begin
      w = 16; m = 8; cmd = b_cmd; nc = int'(b_nc); wt = int'(b_wt); ct = int'(b_ct);
      dat = b_dat; rdy = b_rdy; f = fq1;
    end
    pop = (f.size() > 0) && rdy;
    proto = 0; ovf = 0; wd = 0; push = 0;
    if (cmd) begin
      if (busy[i]) proto = 1;
      busy[i] = 1; exp_n[i] = (nc == 0) ? m : nc; wtype[i] = wt; nb[i] = 0;
    end else if (!busy[i]) begin
      if (ct != 0) proto = 1;
    end else begin
      case (ct)
        1: begin
          if (nb[i] < exp_n[i] - 1) begin
            bt[i][nb[i]] = dat; nb[i]++;
            if (wtype[i] == 1) wd = 1;
          end else begin
            proto = 1; busy[i] = 0;
          end
        end
        2: begin
          if (nb[i] == exp_n[i] - 1) begin
            bt[i][nb[i]] = dat; nb[i]++; push = 1;
            if (wtype[i] == 1) wd = 1;
          end else begin
            proto = 1;
          end
          busy[i] = 0;
        end
        3: begin
          proto = 1; busy[i] = 0;
        end
        default: ;
      endcase
    end
    if (pop) void'(f.pop_front());
    if (push) begin
      e.d = '0;
      for (int k = 0; k < exp_n[i]; k++) e.d = e.d | (128'(bt[i][k]) << (k * w));
      e.n = exp_n[i];
      e.t = wtype[i];
      if (f.size() < 2) begin
        f.push_back(e);
        if (wtype[i] == 2) wd = 1;
      end else begin
        ovf = 1;
      end
    end
    ew[i] = wd; eep[i] = proto; eeo[i] = ovf;
    if (i == 0) fq0 = f; else fq1 = f;
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    chk("vld0", o0_vld, fq0.size() > 0);
    if (fq0.size() > 0) begin
      chk("dat0", o0_dat, fq0[0].d);
      chk("num0", o0_num, fq0[0].n);
      chk("type0", o0_wt, fq0[0].t);
    end
    chk("wdone0", o0_wd, ew[0]);
    chk("eproto0", o0_ep, eep[0]);
    chk("eovf0", o0_eo, eeo[0]);
    chk("vld1", o1_vld, fq1.size() > 0);
    if (fq1.size() > 0) begin
      chk("dat1", o1_dat, fq1[0].d);
      chk("num1", o1_num, fq1[0].n);
      chk("type1", o1_wt, fq1[0].t);
    end
    chk("wdone1", o1_wd, ew[1]);
    chk("eproto1", o1_ep, eep[1]);
    chk("eovf1", o1_eo, eeo[1]);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      model_step(0);
      model_step(1);
    end
    #1;
  endtask

  task automatic drv0(input logic cmd, input int nc, input int wt, input int ct, input int dat);
    a_cmd = cmd; a_nc = nc[1:0]; a_wt = wt[2:0]; a_ct = ct[1:0]; a_dat = dat[7:0];
    tick();
  endtask

  task automatic drv1(input logic cmd, input int nc, input int wt, input int ct, input int dat);
    b_cmd = cmd; b_nc = nc[2:0]; b_wt = wt[2:0]; b_ct = ct[1:0]; b_dat = dat[15:0];
    tick();
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    a_cmd = 0; a_nc = 0; a_wt = 0; a_ct = 0; a_dat = 0; a_rdy = 1;
    b_cmd = 0; b_nc = 0; b_wt = 0; b_ct = 0; b_dat = 0; b_rdy = 1;
    model_reset();
    drv0(0, 0, 0, 0, 0);
    drv0(0, 0, 0, 0, 0);
    neg();
    chk("reset_vld", o0_vld, 0);
    chk("reset_dat", o0_dat, 0);
    chk("reset_wdone", o0_wd, 0);
    rst = 1'b0;

    // SINGLE_WDONE, full 4-beat write
    drv0(1, 0, 2, 0, 0);
    drv0(0, 0, 0, 1, 'h11);
    drv0(0, 0, 0, 1, 'h22);
    drv0(0, 0, 0, 1, 'h33);
    neg();
    chk("single_no_early_vld", o0_vld, 0);
    drv0(0, 0, 0, 2, 'h44);
    neg();
    chk("single_vld", o0_vld, 1);
    chk("single_dat", o0_dat, 32'h44332211);
    chk("single_num", o0_num, 4);
    chk("single_wdone", o0_wd, 1);

    // MULTI_WDONE, 2 beats with a bubble
    drv0(1, 2, 1, 0, 0);
    drv0(0, 0, 0, 1, 'hAA);
    neg();
    chk("multi_wdone_beat0", o0_wd, 1);
    drv0(0, 0, 0, 0, 0);
    neg();
    chk("multi_bubble_wdone", o0_wd, 0);
    drv0(0, 0, 0, 2, 'hBB);
    neg();
    chk("multi_wdone_done", o0_wd, 1);
    chk("multi_dat", o0_dat, 32'h0000BBAA);
    chk("multi_num", o0_num, 2);
    drv0(0, 0, 0, 0, 0);

    // Early DONE with E=3, then a clean write
    drv0(1, 3, 0, 0, 0);
    drv0(0, 0, 0, 1, 'h01);
    drv0(0, 0, 0, 2, 'h02);
    neg();
    chk("early_done_proto", o0_ep, 1);
    chk("early_done_no_push", o0_vld, 0);
    drv0(1, 1, 0, 0, 0);
    drv0(0, 0, 0, 2, 'h5A);
    neg();
    chk("clean1_dat", o0_dat, 32'h5A);

    // New command mid-write
    drv0(1, 2, 1, 0, 0);
    drv0(0, 0, 0, 1, 'h10);
    drv0(1, 2, 0, 0, 0);
    neg();
    chk("midcmd_proto", o0_ep, 1);
    drv0(0, 0, 0, 1, 'h20);
    drv0(0, 0, 0, 2, 'h30);
    neg();
    chk("midcmd_dat", o0_dat, 32'h3020);
    chk("midcmd_type", o0_wt, 0);

    // VALID while idle, then a clean SINGLE write
    drv0(0, 0, 0, 1, 'h55);
    neg();
    chk("idle_valid_proto", o0_ep, 1);
    drv0(1, 1, 2, 0, 0);
    drv0(0, 0, 0, 2, 'h66);
    neg();
    chk("clean3_dat", o0_dat, 32'h66);
    chk("clean3_wdone", o0_wd, 1);
    drv0(0, 0, 0, 0, 0);

    // Overflow: three writes with no consumer
    a_rdy = 0;
    for (int j = 0; j < 3; j++) begin
      drv0(1, 1, 0, 0, 0);
      drv0(0, 0, 0, 2, 'hC1 + j);
    end
    neg();
    chk("ovf_pulse", o0_eo, 1);
    chk("ovf_head1", o0_dat, 32'hC1);
    a_rdy = 1;
    drv0(0, 0, 0, 0, 0);
    neg();
    chk("ovf_head2", o0_dat, 32'hC2);
    drv0(0, 0, 0, 0, 0);
    neg();
    chk("ovf_drained", o0_vld, 0);

    // Pop on the push cycle avoids overflow
    a_rdy = 0;
    for (int j = 0; j < 2; j++) begin
      drv0(1, 1, 0, 0, 0);
      drv0(0, 0, 0, 2, 'hD1 + j);
    end
    drv0(1, 1, 0, 0, 0);
    a_rdy = 1;
    drv0(0, 0, 0, 2, 'hD3);
    a_rdy = 0;
    neg();
    chk("poppush_no_ovf", o0_eo, 0);
    chk("poppush_head", o0_dat, 32'hD2);
    a_rdy = 1;
    drv0(0, 0, 0, 0, 0);
    neg();
    chk("poppush_tail", o0_dat, 32'hD3);
    drv0(0, 0, 0, 0, 0);

    // Wide instance: 8 beats of 16 bits, then a single-beat write
    drv1(1, 0, 0, 0, 0);
    for (int k = 0; k < 7; k++) drv1(0, 0, 0, 1, 'h1111 * (k + 1));
    drv1(0, 0, 0, 2, 'h8888);
    neg();
    chk("wide_dat", o1_dat, 128'h88887777666655554444333322221111);
    chk("wide_num", o1_num, 8);
    drv1(1, 1, 0, 0, 0);
    drv1(0, 0, 0, 2, 'hBEEF);
    neg();
    chk("wide1_dat", o1_dat, 128'hBEEF);
    chk("wide1_num", o1_num, 1);
    drv1(0, 0, 0, 0, 0);

    // Reset during DATA with a queued entry
    a_rdy = 0;
    drv0(1, 1, 0, 0, 0);
    drv0(0, 0, 0, 2, 'h77);
    drv0(1, 2, 1, 0, 0);
    drv0(0, 0, 0, 1, 'h12);
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_async_vld", o0_vld, 0);
    chk("rst_async_wdone", o0_wd, 0);
    drv0(0, 0, 0, 0, 0);
    rst = 1'b0;
    a_rdy = 1;
    drv0(1, 1, 2, 0, 0);
    drv0(0, 0, 0, 2, 'h99);
    neg();
    chk("post_rst_dat", o0_dat, 32'h99);
    chk("post_rst_wdone", o0_wd, 1);
    drv0(0, 0, 0, 0, 0);
    drv0(0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
